// File: rtl/fifo_rd_packer.sv
// Read-side packer for the dual-clock byte FIFO. It packs PACK bytes into one word and
// presents each word on a valid/ready stream. A flush emits a partial word with a keep mask.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    output logic                         rd_en,
    input  logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         i_fifo_empty,
    input  logic                         i_flush,
    output logic [DATA_WIDTH*PACK-1:0]   o_data,
    output logic [PACK-1:0]              o_keep,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [CNT_WIDTH-1:0]         o_word_count,
    output logic                         o_busy
);
    localparam int FW = $clog2(PACK + 1);
    localparam int WW = DATA_WIDTH * PACK;
    localparam logic [FW:0]   PACK_C = (FW+1)'(PACK);
    localparam logic [FW-1:0] LAST_C = FW'(PACK - 1);

    logic [FW-1:0]        fill_q, fill_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 word_hold_q, word_hold_d;
    logic [WW-1:0]        buf_q, buf_d;
    logic [WW-1:0]        data_q, data_d;
    logic [PACK-1:0]      keep_q, keep_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 slot_free_s;
    logic [FW:0]          level_s;
    logic [PACK-1:0]      part_keep_s;
    logic [WW-1:0]        part_data_s;

    // A byte already requested still counts against the word's capacity.
    assign slot_free_s = ~valid_q | i_ready;
    assign level_s     = {1'b0, fill_q} + {{FW{1'b0}}, rd_pend_q};
    assign rd_en       = ~rd_rst & ~i_fifo_empty & ~flush_pend_q & ~word_hold_q & (level_s < PACK_C);

    // Keep mask and zero-padded data for a partial (flushed) word.
    always_comb begin
        part_keep_s = {PACK{1'b0}};
        part_data_s = {WW{1'b0}};
        for (int i = 0; i < PACK; i++) begin
            part_keep_s[i] = (FW'(i) < fill_q);
            part_data_s[i*DATA_WIDTH +: DATA_WIDTH] =
                part_keep_s[i] ? buf_q[i*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
        end
    end

    // Next-state: capture, word completion/hold, flush execution and output handshake.
    always_comb begin
        fill_d       = fill_q;
        rd_pend_d    = rd_en;
        flush_pend_d = flush_pend_q | i_flush;
        word_hold_d  = word_hold_q;
        buf_d        = buf_q;
        data_d       = data_q;
        keep_d       = keep_q;
        valid_d      = valid_q & ~i_ready;
        cnt_d        = cnt_q + CNT_WIDTH'(valid_q & i_ready);

        if (rd_pend_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (FW'(i) == fill_q) begin
                    buf_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_data;
                end else begin
                    buf_d[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (fill_q == LAST_C) begin
                if (slot_free_s) begin
                    data_d  = buf_d;
                    keep_d  = {PACK{1'b1}};
                    valid_d = 1'b1;
                    fill_d  = {FW{1'b0}};
                end else begin
                    word_hold_d = 1'b1;
                    fill_d      = fill_q + FW'(1'b1);
                end
            end else begin
                fill_d = fill_q + FW'(1'b1);
            end
        end else if (word_hold_q) begin
            if (slot_free_s) begin
                data_d      = buf_q;
                keep_d      = {PACK{1'b1}};
                valid_d     = 1'b1;
                fill_d      = {FW{1'b0}};
                word_hold_d = 1'b0;
            end else begin
                word_hold_d = 1'b1;
            end
        end else if (flush_pend_q) begin
            if (slot_free_s) begin
                flush_pend_d = 1'b0;
                fill_d       = {FW{1'b0}};
                if (fill_q != {FW{1'b0}}) begin
                    data_d  = part_data_s;
                    keep_d  = part_keep_s;
                    valid_d = 1'b1;
                end else begin
                    valid_d = valid_q & ~i_ready;
                end
            end else begin
                flush_pend_d = 1'b1;
            end
        end else begin
            fill_d = fill_q;
        end
    end

    // State register with synchronous reset; an in-flight byte is dropped.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            fill_q       <= {FW{1'b0}};
            rd_pend_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            word_hold_q  <= 1'b0;
            buf_q        <= {WW{1'b0}};
            data_q       <= {WW{1'b0}};
            keep_q       <= {PACK{1'b0}};
            valid_q      <= 1'b0;
            cnt_q        <= {CNT_WIDTH{1'b0}};
        end else begin
            fill_q       <= fill_d;
            rd_pend_q    <= rd_pend_d;
            flush_pend_q <= flush_pend_d;
            word_hold_q  <= word_hold_d;
            buf_q        <= buf_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_data       = data_q;
    assign o_keep       = keep_q;
    assign o_valid      = valid_q;
    assign o_word_count = cnt_q;
    assign o_busy       = (fill_q != {FW{1'b0}}) | rd_pend_q | valid_q | flush_pend_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO model feeds the DUT, and the expected words are
// formed from the byte stream the DUT pulled (groups of PACK, or the remainder at a flush).
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PK = 4;
    localparam int CW = 16;
    localparam int WW = DW * PK;

    typedef struct {
        logic [WW-1:0] data;
        logic [PK-1:0] keep;
    } word_t;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          i_fifo_empty;
    logic          i_flush;
    logic [WW-1:0] o_data;
    logic [PK-1:0] o_keep;
    logic          o_valid;
    logic          i_ready;
    logic [CW-1:0] o_word_count;
    logic          o_busy;

    logic [7:0]    fifo_q[$];
    logic [7:0]    part_q[$];
    word_t         exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            n_acc = 0;
    int            since_flush = 100;
    logic [WW-1:0] last_data = '0;
    logic [PK-1:0] last_keep = '0;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .CNT_WIDTH(CW)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .rd_data(rd_data),
        .i_fifo_empty(i_fifo_empty), .i_flush(i_flush), .o_data(o_data), .o_keep(o_keep),
        .o_valid(o_valid), .i_ready(i_ready), .o_word_count(o_word_count), .o_busy(o_busy)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic emit_part();
        word_t w;
        w.data = '0;
        w.keep = '0;
        foreach (part_q[i]) begin
            w.data[i*DW +: DW] = part_q[i];
            w.keep[i] = 1'b1;
        end
        exp_q.push_back(w);
        part_q.delete();
    endtask

    task automatic push_bytes(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(bytes[i*8 +: 8]);
    endtask

    // One clock: check outputs at negedge+1, then advance the model at the posedge.
    task automatic tick();
        logic rd_s, acc_s, fl_s, rst_s;
        logic [7:0] b;
        i_fifo_empty = (fifo_q.size() == 0);
        #1;
        if (rd_rst || fifo_q.size() == 0) chk("rd_en_blocked", rd_en, 0);
        if (exp_q.size() == 0) chk("o_valid_idle", o_valid, 0);
        else if (o_valid) begin
            chk("o_data", o_data, exp_q[0].data);
            chk("o_keep", o_keep, exp_q[0].keep);
        end
        chk("word_count", o_word_count, n_acc[CW-1:0]);
        rd_s  = rd_en;
        acc_s = o_valid & i_ready;
        fl_s  = i_flush;
        rst_s = rd_rst;
        if (acc_s) begin
            last_data = o_data;
            last_keep = o_keep;
        end
        @(posedge rd_clk);
        since_flush++;
        b = rd_data;
        if (rst_s) begin
            part_q.delete();
            exp_q.delete();
            n_acc = 0;
        end else begin
            if (acc_s) begin
                n_acc++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (rd_s && fifo_q.size() > 0) begin
                b = fifo_q.pop_front();
                part_q.push_back(b);
                if (part_q.size() == PK) emit_part();
            end
            if (fl_s) begin
                since_flush = 0;
                if (part_q.size() > 0) emit_part();
            end
        end
        #1 rd_data = b;
        @(negedge rd_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int  r;
        logic done;
        rd_rst = 1'b1; rd_data = '0; i_flush = 1'b0; i_ready = 1'b1; i_fifo_empty = 1'b0;
        fifo_q.push_back(8'hEE);
        @(posedge rd_clk);
        @(negedge rd_clk);

        // Reset held with a non-empty FIFO: no reads, idle outputs.
        for (int i = 0; i < 3; i++) begin
            chk("rst_o_data", o_data, 0);
            tick();
        end
        fifo_q.delete();
        rd_rst = 1'b0;

        // Basic pack.
        push_bytes(64'hCDAB2834, 4);
        run(10);
        chk("basic_word", last_data, 32'hCDAB2834);
        chk("basic_keep", last_keep, 4'hF);
        chk("basic_count", o_word_count, 16'd1);

        // Backpressure: one word on the output, one held, reads stalled.
        i_ready = 1'b0;
        push_bytes(64'h0807060504030201, 8);
        push_bytes(64'h0C0B0A09, 4);
        run(18);
        chk("bp_valid", o_valid, 1);
        chk("bp_data", o_data, 32'h04030201);
        chk("bp_fifo_left", fifo_q.size(), 4);
        chk("bp_rd_en_hold", rd_en, 0);
        i_ready = 1'b1;
        run(14);
        chk("bp_count", o_word_count, 16'd4);
        chk("bp_last", last_data, 32'h0C0B0A09);

        // Partial flush.
        push_bytes(64'hAB2834, 3);
        run(6);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        run(6);
        chk("flush_data", last_data, 32'h00AB2834);
        chk("flush_keep", last_keep, 4'b0111);
        chk("flush_busy", o_busy, 0);
        chk("flush_count", o_word_count, 16'd5);

        // Flush with nothing buffered emits nothing.
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        run(5);
        chk("flush0_count", o_word_count, 16'd5);
        chk("flush0_busy", o_busy, 0);

        // Flush in the cycle the third byte is requested.
        push_bytes(64'hA3A2A1, 3);
        run(2);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        run(6);
        chk("flush_inflight_data", last_data, 32'h00A3A2A1);
        chk("flush_inflight_keep", last_keep, 4'b0111);

        // Reset in the middle of a word.
        push_bytes(64'h2211, 2);
        run(5);
        rd_rst = 1'b1; tick(); rd_rst = 1'b0;
        push_bytes(64'h88776655, 4);
        run(8);
        chk("rst_mid_count", o_word_count, 16'd1);
        chk("rst_mid_data", last_data, 32'h88776655);
        chk("rst_mid_keep", last_keep, 4'hF);

        // Randomised traffic, backpressure and flushes.
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                for (int k = 0; k < 6; k++) fifo_q.push_back(8'($urandom));
            end else if (r < 3) begin
                fifo_q.push_back(8'($urandom));
            end
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = (exp_q.size() == 0 && since_flush >= 3 && $urandom_range(0, 15) == 0);
            tick();
        end

        // Drain everything, flushing the tail.
        i_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            i_flush = (fifo_q.size() == 0 && exp_q.size() == 0 && part_q.size() > 0 && since_flush >= 3);
            tick();
            done = (fifo_q.size() == 0 && exp_q.size() == 0 && part_q.size() == 0 && since_flush >= 3);
        end
        i_flush = 1'b0;
        chk("drain_done", done, 1);
        chk("drain_busy", o_busy, 0);
        chk("drain_count", o_word_count, n_acc[CW-1:0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side consumer for the team's dual-clock byte FIFO. It runs entirely in the rd_clk domain and drives the FIFO read port: rd_en out, rd_data and empty in. It packs PACK consecutive bytes into one word and presents each word on a valid/ready stream. A flush request emits a partially filled word with a byte-keep mask.

Parameters:
DATA_WIDTH, 8, FIFO byte width.
PACK, 4, bytes per output word (legal 1..8).
CNT_WIDTH, 16, width of delivered-word counter.

Ports:
rd_clk  in  1  read-domain clock; all logic on rising edge.
rd_rst  in  1  reset; synchronous, active-high.
rd_en  out  1  FIFO read strobe.
rd_data  in  DATA_WIDTH  FIFO read data; valid on the edge after rd_en is sampled high.
i_fifo_empty  in  1  FIFO empty flag.
i_flush  in  1  one-cycle pulse; emit the partial word.
o_data  out  DATA_WIDTH*PACK  packed word; the first byte read occupies bits [DATA_WIDTH-1:0].
o_keep  out  PACK  bit i=1 means byte lane i is valid.
o_valid  out  1  word available.
i_ready  in  1  downstream accept.
o_word_count  out  CNT_WIDTH  count of accepted words; wraps modulo 2^CNT_WIDTH.
o_busy  out  1  fill!=0 | rd_pend | o_valid | flush_pend.

Behaviour:
- Reset (rd_rst high at an edge):
  - fill=0, rd_pend=0, flush_pend=0, word_hold=0.
  - o_valid=0, o_data=0, o_keep=0, o_word_count=0.
  - rd_en is combinationally 0 while rd_rst=1.
  - A byte in flight at reset is discarded. The system resets both FIFO sides together.
- Read latency: rd_pend <= rd_en. When rd_pend=1, rd_data is captured into lane `fill`, and fill increments.
- rd_en = ~rd_rst & ~i_fifo_empty & ~flush_pend & ~word_hold & (fill + rd_pend < PACK).
- Word completion: the byte landing at lane PACK-1 completes the word.
  - Output slot free (o_valid=0, or o_valid&i_ready in that cycle): load o_data, set o_keep=all ones, set o_valid=1, set fill=0, all on the same edge.
  - Output slot not free: set word_hold=1 and keep the bytes. No reads occur until the word moves to the output on the first edge where the slot frees.
- Throughput: sustained rate is at least one word per PACK+1 cycles. No byte is lost or duplicated under any backpressure.
- Output handshake:
  - o_data and o_keep are stable while o_valid=1 and i_ready=0.
  - o_valid clears after acceptance unless a new word is loaded on the same edge.
  - o_word_count increments on every edge with o_valid & i_ready.
- Flush:
  - i_flush sets flush_pend, which blocks new reads.
  - The flush executes on the first edge where rd_pend=0 (any in-flight byte is captured first), word_hold=0, and the output slot is free.
  - Execution with fill>0: o_data gets the held bytes with unused lanes zeroed, o_keep = (1<<fill)-1, o_valid=1, fill=0, flush_pend=0.
  - Execution with fill=0: flush_pend clears and no word is emitted.
  - i_flush while flush_pend=1 is absorbed.
  - If the in-flight byte completes a full word, that word is emitted normally and the flush then finds fill=0.
- PACK=1: every byte becomes a word with o_keep=1; flush never emits.

Test Plan:
1. Reset: rd_rst=1 for 3 cycles with i_fifo_empty=0 -> rd_en=0, o_valid=0, o_data=0, o_word_count=0 throughout.
2. Basic pack (PACK=4): FIFO model holds 34,28,AB,CD; i_ready=1 -> one word o_data=0xCDAB2834, o_keep=4'hF, o_word_count=1. rd_en falls once the FIFO is empty.
3. Backpressure: FIFO holds 01..08; i_ready=0 until cycle 20 -> o_valid=1 with 0x04030201 held stable, rd_en=0 after byte 08 is captured. Raising i_ready yields 0x04030201 then 0x08070605, count=2, no loss.
4. Partial flush: 34,28,AB then empty; i_flush pulse -> o_data=0x00AB2834, o_keep=4'b0111, fill=0 afterward.
5. Flush edge cases:
   - Flush with fill=0 -> no o_valid.
   - Flush asserted the cycle rd_en is high for byte 3 of 3 available -> the emitted word includes that byte, o_keep=4'b0111.
6. Reset mid-word: capture 11,22, pulse rd_rst one cycle, then feed 55,66,77,88 -> a single word 0x88776655 with no residue of 11,22, and count=1.
